div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Initiator side of the DivCtrl/DivDone divider handshake, used by the multicycle MIPS datapath.
//  Latches operands on a DIV request, drives the divider and holds it until completion.
//  Commits the divider's HI/LO into the architectural HI/LO registers; raises a one-cycle exception on Div0 or watchdog timeout.
//  Sits between the control unit (start/busy/done/exc) and the div unit.
// PARAMETERS
//  DATA_W          32  operand / HI / LO width
//  TIMEOUT_CYCLES  64  WAIT cycles before watchdog abort (divider nominally needs <=34)
//  CNT_W           7   wait-counter width; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       DIV request from control unit (sampled in IDLE only)
//  op_a       in   DATA_W  dividend, sampled with start
//  op_b       in   DATA_W  divisor, sampled with start
//  div_a      out  DATA_W  held dividend -> divider RegAOut
//  div_b      out  DATA_W  held divisor  -> divider RegBOut
//  DivCtrl    out  1       divider run request
//  DivDone    in   1       divider completion
//  Div0       in   1       divider divide-by-zero flag
//  HI         in   DATA_W  divider remainder
//  LO         in   DATA_W  divider quotient
//  busy       out  1       operation in flight (control unit stalls)
//  op_done    out  1       one-cycle pulse: HI/LO committed
//  div_exc    out  1       one-cycle pulse: operation aborted
//  exc_tmo    out  1       qualifies div_exc: 1=timeout, 0=Div0
//  mthi/mtlo  in   1       CPU writes of hi_q/lo_q from mt_data (IDLE only)
//  mt_data    in   DATA_W  MTHI/MTLO data
//  hi_q/lo_q  out  DATA_W  architectural HI/LO (MFHI/MFLO source)
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; count 0. Reset in any state aborts with no done/exc pulse.
//  FSM: IDLE -> WAIT -> {DONE | EXC} -> IDLE. All outputs are registered.
//  IDLE: busy=0, DivCtrl=0.
//   - start=1: latch op_a/op_b into div_a/div_b, count<=0, go WAIT.
//   - mthi/mtlo write hi_q/lo_q. If either is high together with start, start wins and the write is dropped.
//  WAIT: busy=1, DivCtrl=1. div_a/div_b held stable. count increments each cycle.
//   - Checked in priority order:
//     1. Div0=1 -> EXC, exc_tmo=0.
//     2. DivDone=1 -> hi_q<=HI, lo_q<=LO on that edge; go DONE.
//     3. Timeout: count==TIMEOUT_CYCLES-1 -> EXC, exc_tmo=1.
//   - Div0 together with DivDone: Div0 wins and hi_q/lo_q are untouched.
//   - start, mthi and mtlo are ignored.
//  DONE: DivCtrl=0, busy=1, op_done=1 for 1 cycle, then IDLE.
//  EXC: DivCtrl=0, busy=1, div_exc=1 for 1 cycle, exc_tmo held valid; hi_q/lo_q unchanged; then IDLE.
//  Latency: start edge to op_done = divider cycles + 2. A back-to-back start is accepted on the first IDLE cycle.
//  No arithmetic is done here; HI/LO are copied verbatim, no sign or width conversion.
// CONFIGURATION
//  DIV_WATCHDOG_EN defined: timeout path active as above.
//  Undefined: no counter logic; exc_tmo tied 0; WAIT waits for DivDone/Div0 indefinitely.
// STRUCTURE
//  Package div_ctrl_pkg:
//   - state enum {IDLE, WAIT, DONE, EXC}
//   - localparams for exception cause (CAUSE_DIV0, CAUSE_TMO)
//  Sub-module hilo_regs: HI/LO register pair.
//   - Two write sources: divider commit and MTHI/MTLO; commit has priority.
//   - Sync reset to 0.
//  FSM, operand latch and watchdog stay in this module.
// TESTING
//  1. start, op_a=23, op_b=7; model divider returns HI=2/LO=3 after 33 cycles -> op_done 1 cycle, hi_q=2, lo_q=3, DivCtrl low in DONE.
//  2. op_a=100, op_b=0; divider asserts Div0 at cycle 2 -> div_exc=1, exc_tmo=0, hi_q/lo_q keep prior values (2/3).
//  3. Div0 and DivDone same cycle (HI=9, LO=9) -> div_exc only, no commit, no op_done.
//  4. DIV_WATCHDOG_EN, divider never responds -> div_exc with exc_tmo=1 exactly 64 WAIT cycles after start; busy low next cycle.
//  5. reset asserted mid-WAIT (cycle 10) -> next cycle all outputs 0, IDLE; a new start is accepted immediately.
//  6. mthi with mt_data=0xDEADBEEF in IDLE -> hi_q updates; mtlo with 0x1 during WAIT -> ignored; op_a changed during WAIT -> div_a unchanged.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared types for the DIV issue controller.
//   state_t    : issue FSM states
//   CAUSE_DIV0 : exception cause, divider reported divide-by-zero
//   CAUSE_TMO  : exception cause, watchdog expired
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    EXC  = 2'd3
  } state_t;

  localparam logic CAUSE_DIV0 = 1'b0;
  localparam logic CAUSE_TMO  = 1'b1;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// DivCtrl/DivDone handshake between the issue controller and the divider.
//   master (issue side) : drives div_a, div_b, DivCtrl; receives DivDone, Div0, HI, LO
//   slave  (divider)    : the mirror image
interface div_issue_ctrl_if #(
  parameter int unsigned DATA_W = 32
);

  logic [DATA_W-1:0] div_a;
  logic [DATA_W-1:0] div_b;
  logic              DivCtrl;
  logic              DivDone;
  logic              Div0;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output div_a, div_b, DivCtrl,
    input  DivDone, Div0, HI, LO
  );

  modport slave (
    input  div_a, div_b, DivCtrl,
    output DivDone, Div0, HI, LO
  );

endinterface

// File: rtl/div_issue_ctrl_hilo_regs.sv
// Architectural HI/LO register pair.
//   clk, reset      : clock, synchronous active-high reset (clears to 0)
//   commit          : load hi_in/lo_in (divider result); wins over MTHI/MTLO
//   hi_in, lo_in    : divider remainder / quotient
//   mthi, mtlo      : CPU write strobes for hi_q / lo_q from mt_data
//   mt_data         : MTHI/MTLO data
//   hi_q, lo_q      : registered HI/LO
module hilo_regs #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] mt_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  // Commit and MTHI/MTLO are mutually exclusive by FSM state; priority kept anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= hi_in;
      lo_q <= lo_in;
    end else begin
      if (mthi) hi_q <= mt_data;
      if (mtlo) lo_q <= mt_data;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Initiator side of the DivCtrl/DivDone divider handshake.
// Latches operands on start, runs the divider until DivDone/Div0 (or watchdog
// timeout), commits HI/LO and pulses op_done or div_exc for one cycle.
//   clk, reset        : clock, synchronous active-high reset
//   start, op_a, op_b : DIV request and operands (accepted in IDLE only)
//   div               : divider handshake (div_a, div_b, DivCtrl / DivDone, Div0, HI, LO)
//   busy              : operation in flight
//   op_done           : one-cycle pulse, HI/LO committed
//   div_exc, exc_tmo  : one-cycle abort pulse and its cause (1=timeout, 0=Div0)
//   mthi, mtlo, mt_data : CPU writes of HI/LO (IDLE only, dropped if start)
//   hi_q, lo_q        : architectural HI/LO
// Build option: define DIV_WATCHDOG_EN to enable the WAIT timeout.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  div_issue_ctrl_if.master  div,
  output logic              busy,
  output logic              op_done,
  output logic              div_exc,
  output logic              exc_tmo,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] mt_data,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] div_a_q, div_b_q;
  logic              busy_q, divctrl_q, op_done_q, div_exc_q, exc_tmo_q;
  logic              busy_d, divctrl_d, op_done_d, div_exc_d, exc_tmo_d;
  logic              cause_d;
  logic              opnd_load_c;
  logic              commit_c;
  logic              mthi_wr_c;
  logic              mtlo_wr_c;

`ifdef DIV_WATCHDOG_EN
  logic [CNT_W-1:0]  count_q;
  logic              timeout_c;

  assign timeout_c = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT-cycle counter, cleared when an operation is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (opnd_load_c) begin
      count_q <= '0;
    end else if (state_q == WAIT) begin
      count_q <= count_q + CNT_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT_CYCLES), 32'(CNT_W)};
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    cause_d     = CAUSE_DIV0;
    opnd_load_c = 1'b0;
    commit_c    = 1'b0;
    mthi_wr_c   = 1'b0;
    mtlo_wr_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT;
          opnd_load_c = 1'b1;
        end else begin
          mthi_wr_c = mthi;
          mtlo_wr_c = mtlo;
        end
      end
      WAIT: begin
        // Div0 outranks DivDone so a faulting result is never committed.
        if (div.Div0) begin
          state_d = EXC;
          cause_d = CAUSE_DIV0;
        end else if (div.DivDone) begin
          state_d  = DONE;
          commit_c = 1'b1;
        end
`ifdef DIV_WATCHDOG_EN
        else if (timeout_c) begin
          state_d = EXC;
          cause_d = CAUSE_TMO;
        end
`endif
      end
      DONE:    state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    divctrl_d = (state_d == WAIT);
    op_done_d = (state_d == DONE);
    div_exc_d = (state_d == EXC);
    exc_tmo_d = (state_d == EXC) && (cause_d == CAUSE_TMO);
  end

  // State, operand latch and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      div_a_q   <= '0;
      div_b_q   <= '0;
      busy_q    <= 1'b0;
      divctrl_q <= 1'b0;
      op_done_q <= 1'b0;
      div_exc_q <= 1'b0;
      exc_tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (opnd_load_c) begin
        div_a_q <= op_a;
        div_b_q <= op_b;
      end
      busy_q    <= busy_d;
      divctrl_q <= divctrl_d;
      op_done_q <= op_done_d;
      div_exc_q <= div_exc_d;
      exc_tmo_q <= exc_tmo_d;
    end
  end

  assign div.div_a   = div_a_q;
  assign div.div_b   = div_b_q;
  assign div.DivCtrl = divctrl_q;
  assign busy        = busy_q;
  assign op_done     = op_done_q;
  assign div_exc     = div_exc_q;
  assign exc_tmo     = exc_tmo_q;

  hilo_regs #(
    .DATA_W(DATA_W)
  ) u_hilo (
    .clk     (clk),
    .reset   (reset),
    .commit  (commit_c),
    .hi_in   (div.HI),
    .lo_in   (div.LO),
    .mthi    (mthi_wr_c),
    .mtlo    (mtlo_wr_c),
    .mt_data (mt_data),
    .hi_q    (hi_q),
    .lo_q    (lo_q)
  );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl; the bench plays the divider.
module tb_div_issue_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 64;

  logic          clk = 1'b0;
  logic          reset, start, mthi, mtlo;
  logic [DW-1:0] op_a, op_b, mt_data, hi_q, lo_q;
  logic          busy, op_done, div_exc, exc_tmo;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] arch_hi, arch_lo;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int unsigned   resp_cyc;   // WAIT cycle carrying the divider response; 0 = never
    logic          done;
    logic          div0;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          exp_done;
    logic          exp_exc;
    logic          exp_tmo;
    logic [DW-1:0] exp_hi;
    logic [DW-1:0] exp_lo;
  } vec_t;

  div_issue_ctrl_if #(.DATA_W(DW)) dif ();

  div_issue_ctrl #(
    .DATA_W(DW), .TIMEOUT_CYCLES(TMO), .CNT_W(7)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .div(dif), .busy(busy), .op_done(op_done), .div_exc(div_exc),
    .exc_tmo(exc_tmo), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outcome of one operation from the handshake rules alone.
  function automatic vec_t predict(input vec_t v, input logic [DW-1:0] h, input logic [DW-1:0] l);
    vec_t r = v;
    r.exp_done = 1'b0; r.exp_exc = 1'b0; r.exp_tmo = 1'b0;
    r.exp_hi   = h;    r.exp_lo  = l;
    if (v.resp_cyc == 0 || v.resp_cyc > TMO) begin
      r.exp_exc = 1'b1; r.exp_tmo = 1'b1;
    end else if (v.div0) begin
      r.exp_exc = 1'b1;
    end else begin
      r.exp_done = 1'b1; r.exp_hi = v.hi; r.exp_lo = v.lo;
    end
    return r;
  endfunction

  // Issues one operation from IDLE; returns in the first IDLE cycle afterwards.
  task automatic run_op(input vec_t v, input string tag);
    int unsigned wait_cyc;
    wait_cyc = (v.resp_cyc == 0 || v.resp_cyc > TMO) ? TMO : v.resp_cyc;
    start = 1'b1; op_a = v.a; op_b = v.b;
    mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); mt_data = $urandom;
    tick();
    for (int c = 1; c <= int'(wait_cyc); c++) begin
      check($sformatf("%s w%0d status", tag, c), 64'({busy, dif.DivCtrl, op_done, div_exc}), 64'(4'b1100));
      check($sformatf("%s w%0d operands", tag, c), {dif.div_a, dif.div_b}, {v.a, v.b});
      check($sformatf("%s w%0d hilo", tag, c), {hi_q, lo_q}, {arch_hi, arch_lo});
      if (c == int'(v.resp_cyc)) begin
        dif.DivDone = v.done; dif.Div0 = v.div0; dif.HI = v.hi; dif.LO = v.lo;
      end else begin
        dif.DivDone = 1'b0; dif.Div0 = 1'b0; dif.HI = $urandom; dif.LO = $urandom;
      end
      start = 1'($urandom_range(0, 1)); mthi = 1'($urandom_range(0, 1));
      mtlo = 1'($urandom_range(0, 1)); mt_data = $urandom;
      op_a = $urandom; op_b = $urandom;
      tick();
    end
    dif.DivDone = 1'b0; dif.Div0 = 1'b0;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check($sformatf("%s end status", tag), 64'({busy, dif.DivCtrl, op_done, div_exc, exc_tmo}),
          64'({1'b1, 1'b0, v.exp_done, v.exp_exc, v.exp_tmo}));
    check($sformatf("%s end hilo", tag), {hi_q, lo_q}, {v.exp_hi, v.exp_lo});
    arch_hi = v.exp_hi; arch_lo = v.exp_lo;
    tick();
    check($sformatf("%s idle status", tag), 64'({busy, dif.DivCtrl, op_done, div_exc, exc_tmo}), 64'(0));
  endtask

  vec_t tbl [4];
  vec_t v;

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op_a = '0; op_b = '0; mt_data = '0;
    dif.DivDone = 1'b0; dif.Div0 = 1'b0; dif.HI = '0; dif.LO = '0;
    tick(); tick();
    check("reset status", 64'({busy, dif.DivCtrl, op_done, div_exc, exc_tmo}), 64'(0));
    check("reset hilo", {hi_q, lo_q}, 64'(0));
    check("reset operands", {dif.div_a, dif.div_b}, 64'(0));
    reset = 1'b0; arch_hi = '0; arch_lo = '0;

    // Directed vectors: normal divide, Div0, Div0+DivDone, fastest response.
    tbl[0] = '{a:32'd23, b:32'd7, resp_cyc:33, done:1'b1, div0:1'b0, hi:32'd2, lo:32'd3,
               exp_done:1'b1, exp_exc:1'b0, exp_tmo:1'b0, exp_hi:32'd2, exp_lo:32'd3};
    tbl[1] = '{a:32'd100, b:32'd0, resp_cyc:2, done:1'b0, div0:1'b1, hi:32'hFFFF_FFFF, lo:32'h0,
               exp_done:1'b0, exp_exc:1'b1, exp_tmo:1'b0, exp_hi:32'd2, exp_lo:32'd3};
    tbl[2] = '{a:32'd55, b:32'd11, resp_cyc:5, done:1'b1, div0:1'b1, hi:32'd9, lo:32'd9,
               exp_done:1'b0, exp_exc:1'b1, exp_tmo:1'b0, exp_hi:32'd2, exp_lo:32'd3};
    tbl[3] = '{a:32'h8000_0000, b:32'hFFFF_FFFF, resp_cyc:1, done:1'b1, div0:1'b0,
               hi:32'h0, lo:32'h8000_0000, exp_done:1'b1, exp_exc:1'b0, exp_tmo:1'b0,
               exp_hi:32'h0, exp_lo:32'h8000_0000};
    for (int i = 0; i < 4; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // MTHI/MTLO in IDLE.
    mthi = 1'b1; mt_data = 32'hDEAD_BEEF;
    tick();
    mthi = 1'b0;
    check("mthi hi", 64'(hi_q), 64'(32'hDEAD_BEEF));
    check("mthi lo", 64'(lo_q), 64'(arch_lo));
    arch_hi = 32'hDEAD_BEEF;
    mtlo = 1'b1; mt_data = 32'h1;
    tick();
    mtlo = 1'b0;
    check("mtlo lo", 64'(lo_q), 64'(32'h1));
    arch_lo = 32'h1;

    // Reset during WAIT cycle 10, then an immediate new operation.
    start = 1'b1; op_a = 32'd5; op_b = 32'd6;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    check("pre-reset busy", 64'({busy, dif.DivCtrl}), 64'(2'b11));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset status", 64'({busy, dif.DivCtrl, op_done, div_exc, exc_tmo}), 64'(0));
    check("midreset data", {hi_q, lo_q, dif.div_a, dif.div_b}, 128'(0));
    arch_hi = '0; arch_lo = '0;
    v = '{a:32'd77, b:32'd8, resp_cyc:3, done:1'b1, div0:1'b0, hi:32'd5, lo:32'd9,
          exp_done:1'b0, exp_exc:1'b0, exp_tmo:1'b0, exp_hi:'0, exp_lo:'0};
    run_op(predict(v, arch_hi, arch_lo), "post_reset");

`ifdef DIV_WATCHDOG_EN
    // Silent divider, and responses on / just past the last WAIT cycle.
    v.resp_cyc = 0;
    run_op(predict(v, arch_hi, arch_lo), "wd_silent");
    v.resp_cyc = TMO; v.hi = 32'hA5A5_0001; v.lo = 32'h5A5A_0002;
    run_op(predict(v, arch_hi, arch_lo), "wd_last");
    v.resp_cyc = TMO + 1;
    run_op(predict(v, arch_hi, arch_lo), "wd_late");
`else
    // Without the watchdog WAIT persists until the divider answers.
    start = 1'b1; op_a = 32'd9; op_b = 32'd3;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 150; c++) begin
      check($sformatf("nowd w%0d", c), 64'({busy, dif.DivCtrl, div_exc, exc_tmo}), 64'(4'b1100));
      tick();
    end
    dif.DivDone = 1'b1; dif.HI = 32'd0; dif.LO = 32'd3;
    tick();
    dif.DivDone = 1'b0;
    check("nowd done", 64'({busy, dif.DivCtrl, op_done, div_exc}), 64'(4'b1010));
    check("nowd hilo", {hi_q, lo_q}, {32'd0, 32'd3});
    arch_hi = 32'd0; arch_lo = 32'd3;
    tick();
    check("nowd idle", 64'(busy), 64'(0));
`endif

    // Randomized operations with idle MTHI/MTLO traffic between them.
    for (int n = 0; n < 40; n++) begin
      int unsigned idle_n;
      int unsigned kind;
      idle_n = $urandom_range(0, 2);
      for (int k = 0; k < int'(idle_n); k++) begin
        mthi = 1'($urandom_range(0, 1)); mtlo = 1'($urandom_range(0, 1)); mt_data = $urandom;
        tick();
        if (mthi) arch_hi = mt_data;
        if (mtlo) arch_lo = mt_data;
        mthi = 1'b0; mtlo = 1'b0;
        check($sformatf("rnd%0d idle%0d", n, k), {hi_q, lo_q, 31'(0), busy}, {arch_hi, arch_lo, 32'(0)});
      end
      kind = $urandom_range(0, 3);
      v.a = $urandom; v.b = $urandom; v.hi = $urandom; v.lo = $urandom;
      v.done = (kind != 2);
      v.div0 = (kind >= 2);
`ifdef DIV_WATCHDOG_EN
      v.resp_cyc = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 70);
`else
      v.resp_cyc = $urandom_range(1, 40);
`endif
      run_op(predict(v, arch_hi, arch_lo), $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
